// File: rtl/cfu_pkg.sv
// Shared CFU types: sequencer state encoding and buffer word/address types.
`timescale 1ns/1ps
package cfu_pkg;

  localparam int CFU_ADDR_W = 10;
  localparam int CFU_DATA_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    ISSUE,
    DRAIN,
    RESP
  } seq_state_e;

  typedef logic [CFU_DATA_W-1:0] word_t;
  typedef logic [CFU_ADDR_W-1:0] addr_t;

endpackage

// File: rtl/mac_sequencer.sv
// MAC sequencer: streams one input/weight word pair per cycle into the SIMD MAC
// for a single dot-product job, then returns the accumulator on a valid/ready port.
`timescale 1ns/1ps
module mac_sequencer
  import cfu_pkg::*;
#(
  parameter int ADDR_W  = CFU_ADDR_W,
  parameter int DATA_W  = CFU_DATA_W,
  parameter int MAC_LAT = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_in_base,
  input  logic [ADDR_W-1:0] cmd_wt_base,
  input  logic [ADDR_W:0]   cmd_len,
  input  logic              cmd_clear,
  input  logic              abort,
  output logic              in_rd_en,
  output logic [ADDR_W-1:0] in_rd_addr,
  input  logic [DATA_W-1:0] in_rd_data,
  output logic              wt_rd_en,
  output logic [ADDR_W-1:0] wt_rd_addr,
  input  logic [DATA_W-1:0] wt_rd_data,
  output logic              mac_clear,
  output logic              mac_en,
  output logic [DATA_W-1:0] mac_a,
  output logic [DATA_W-1:0] mac_b,
  input  logic [31:0]       mac_acc,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_result,
  output logic              busy
);

  // Drain counter only has to reach MAC_LAT (DRAIN lasts MAC_LAT+1 cycles).
  localparam int DRAIN_W = (MAC_LAT < 2) ? 1 : $clog2(MAC_LAT + 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(MAC_LAT);

  seq_state_e          state, state_nxt;
  logic [ADDR_W-1:0]   in_base, wt_base;
  logic [ADDR_W:0]     len, idx, idx_inc;
  logic [DRAIN_W-1:0]  drain_cnt;
  logic                mac_en_q;
  logic                accept, issue_last, drain_last, len_zero;

  assign accept     = cmd_valid & cmd_ready;
  assign idx_inc    = idx + (ADDR_W+1)'(1);
  assign issue_last = (idx_inc == len);
  assign drain_last = (state == DRAIN) && (drain_cnt == DRAIN_LAST);
  assign len_zero   = (len == '0);

  // Operands go straight from the buffers; the read issued last cycle lands now.
  assign mac_a      = in_rd_data;
  assign mac_b      = wt_rd_data;
  assign mac_en     = mac_en_q;
  assign wt_rd_en   = in_rd_en;
  assign in_rd_addr = in_rd_en ? in_base + idx[ADDR_W-1:0] : '0;
  assign wt_rd_addr = in_rd_en ? wt_base + idx[ADDR_W-1:0] : '0;
  assign busy       = (state != IDLE);
  assign rsp_valid  = (state == RESP);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next state and per-state strobes; abort kills strobes in the same cycle.
  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    in_rd_en  = 1'b0;
    mac_clear = 1'b0;
    unique case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          if (cmd_clear)            state_nxt = CLEAR;
          else if (cmd_len != '0)   state_nxt = ISSUE;
          else                      state_nxt = DRAIN;
        end
      end
      CLEAR: begin
        mac_clear = ~abort;
        state_nxt = len_zero ? DRAIN : ISSUE;
      end
      ISSUE: begin
        in_rd_en = ~abort;
        if (issue_last) state_nxt = DRAIN;
      end
      DRAIN: if (drain_last) state_nxt = RESP;
      RESP:  if (rsp_ready)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort && state != IDLE) state_nxt = IDLE;
  end

  // Job registers, index/drain counters, mac_en delay and result capture.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_base    <= '0;
      wt_base    <= '0;
      len        <= '0;
      idx        <= '0;
      drain_cnt  <= '0;
      mac_en_q   <= 1'b0;
      rsp_result <= '0;
    end else begin
      if (accept) begin
        in_base <= cmd_in_base;
        wt_base <= cmd_wt_base;
        len     <= cmd_len;
        idx     <= '0;
      end else if (in_rd_en) begin
        idx <= idx_inc;
      end
      drain_cnt <= (state == DRAIN && !drain_last) ? drain_cnt + DRAIN_W'(1) : '0;
      // in_rd_en is already low under abort, so an aborted issue never reaches the MAC.
      mac_en_q  <= in_rd_en;
      if (drain_last && !abort) rsp_result <= mac_acc;
    end
  end

endmodule

// File: tb/tb_mac_sequencer.sv
// Self-checking bench for mac_sequencer: buffer + MAC environment models and a
// job-level reference (sum of lane dot products, expected latency and strobe counts).
`timescale 1ns/1ps
module tb_mac_sequencer;

  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;

  logic              clk, reset_n;
  logic              cmd_valid, cmd_ready, cmd_clear, abort;
  logic [AW-1:0]     cmd_in_base, cmd_wt_base;
  logic [AW:0]       cmd_len;
  logic              in_rd_en, wt_rd_en, mac_clear, mac_en, rsp_valid, rsp_ready, busy;
  logic [AW-1:0]     in_rd_addr, wt_rd_addr;
  logic [31:0]       in_rd_data, wt_rd_data, mac_a, mac_b;
  logic signed [31:0] mac_acc, rsp_result;

  logic [31:0] in_mem [DEPTH];
  logic [31:0] wt_mem [DEPTH];

  int checks = 0, failures = 0;
  int rd_cnt, men_cnt, clr_cnt, men_run, men_max;
  int mon_ib, mon_wb;
  int model_acc = 0;
  int last_res  = 0;

  mac_sequencer #(.ADDR_W(AW), .DATA_W(32), .MAC_LAT(1)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_in_base(cmd_in_base), .cmd_wt_base(cmd_wt_base),
    .cmd_len(cmd_len), .cmd_clear(cmd_clear), .abort(abort),
    .in_rd_en(in_rd_en), .in_rd_addr(in_rd_addr), .in_rd_data(in_rd_data),
    .wt_rd_en(wt_rd_en), .wt_rd_addr(wt_rd_addr), .wt_rd_data(wt_rd_data),
    .mac_clear(mac_clear), .mac_en(mac_en), .mac_a(mac_a), .mac_b(mac_b),
    .mac_acc(mac_acc), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int dot4(input logic [31:0] a, input logic [31:0] b);
    int s = 0;
    for (int i = 0; i < 4; i++) s += $signed(a[8*i +: 8]) * $signed(b[8*i +: 8]);
    return s;
  endfunction

  task automatic chk(input string tag, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Synchronous-read buffers and a MAC with one cycle of latency.
  always @(posedge clk) begin
    if (in_rd_en) in_rd_data <= in_mem[in_rd_addr];
    if (wt_rd_en) wt_rd_data <= wt_mem[wt_rd_addr];
    if (mac_clear)   mac_acc <= 0;
    else if (mac_en) mac_acc <= mac_acc + dot4(mac_a, mac_b);
  end

  // Strobe monitor: address sequence, read/mac_en/clear counts, longest mac_en run.
  always @(negedge clk) begin
    if (reset_n) begin
      if (in_rd_en) begin
        chk("in_addr", in_rd_addr, (mon_ib + rd_cnt) % DEPTH);
        chk("wt_addr", wt_rd_addr, (mon_wb + rd_cnt) % DEPTH);
        chk("wt_rd_en", wt_rd_en, 1);
        rd_cnt++;
      end
      if (mac_en) begin
        men_cnt++;
        men_run++;
        if (men_run > men_max) men_max = men_run;
      end else men_run = 0;
      if (mac_clear) clr_cnt++;
    end
  end

  task automatic start_job(input int ib, input int wb, input int len, input bit clr);
    @(negedge clk);
    cmd_valid = 1; cmd_in_base = AW'(ib); cmd_wt_base = AW'(wb);
    cmd_len = (AW+1)'(len); cmd_clear = clr;
    mon_ib = ib; mon_wb = wb;
    chk("cmd_ready_idle", cmd_ready, 1);
    @(posedge clk); #1;
    cmd_valid = 0;
    rd_cnt = 0; men_cnt = 0; clr_cnt = 0; men_run = 0; men_max = 0;
  endtask

  // Latency is counted in rising edges, the accept edge being the first.
  task automatic run_job(input int ib, input int wb, input int len, input bit clr,
                         input int hold, input bit has_k, input int k);
    int exp_res, n;
    exp_res = clr ? 0 : model_acc;
    for (int i = 0; i < len; i++)
      exp_res += dot4(in_mem[(ib + i) % DEPTH], wt_mem[(wb + i) % DEPTH]);
    start_job(ib, wb, len, clr);
    n = 1;
    @(negedge clk);
    while (!rsp_valid && n < 3000) begin @(negedge clk); n++; end
    chk("latency", n, len + 3 + int'(clr));
    chk("result", rsp_result, exp_res);
    if (has_k) chk("result_const", rsp_result, k);
    chk("rd_count", rd_cnt, len);
    chk("mac_en_count", men_cnt, len);
    chk("mac_en_run", men_max, len);
    chk("clear_count", clr_cnt, int'(clr));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", rsp_valid, 1);
      chk("hold_result", rsp_result, exp_res);
      chk("hold_cmd_ready", cmd_ready, 0);
    end
    rsp_ready = 1;
    @(posedge clk); #1;
    rsp_ready = 0;
    chk("idle_busy", busy, 0);
    chk("idle_cmd_ready", cmd_ready, 1);
    chk("idle_rsp_valid", rsp_valid, 0);
    model_acc = exp_res;
    last_res  = exp_res;
  endtask

  initial begin
    int ib, wb;
    bit seen;
    reset_n = 0; cmd_valid = 0; cmd_in_base = '0; cmd_wt_base = '0; cmd_len = '0;
    cmd_clear = 0; abort = 0; rsp_ready = 0; mac_acc = 0;
    in_rd_data = '0; wt_rd_data = '0;
    mon_ib = 0; mon_wb = 0;
    rd_cnt = 0; men_cnt = 0; clr_cnt = 0; men_run = 0; men_max = 0;
    for (int i = 0; i < DEPTH; i++) begin in_mem[i] = '0; wt_mem[i] = '0; end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_strobes", {in_rd_en, wt_rd_en, mac_clear, mac_en, rsp_valid, busy}, 0);
    chk("rst_addr", {in_rd_addr, wt_rd_addr}, 0);
    chk("rst_result", rsp_result, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    @(negedge clk); reset_n = 1;

    // Basic job with clear.
    for (int i = 0; i < 4; i++) begin
      in_mem[i] = {4{8'(i + 1)}};
      wt_mem[i] = 32'h01010101;
    end
    run_job(0, 0, 4, 1, 0, 1, 40);
    // Accumulate on top without clearing.
    for (int i = 0; i < 4; i++) wt_mem[i] = 32'h02020202;
    run_job(0, 0, 4, 0, 0, 1, 120);
    // Empty job with clear.
    run_job(5, 9, 0, 1, 0, 1, 0);
    // Address wrap on the input side, negative lanes.
    for (int i = 0; i < 4; i++) begin
      in_mem[(1022 + i) % DEPTH] = 32'hFFFEFDFC;
      wt_mem[i] = 32'h01010101;
    end
    run_job(1022, 0, 4, 1, 0, 1, -40);
    // Response back-pressure.
    run_job(1022, 0, 4, 1, 5, 1, -40);

    // Random contents and jobs.
    for (int i = 0; i < DEPTH; i++) begin in_mem[i] = $urandom; wt_mem[i] = $urandom; end
    for (int j = 0; j < 8; j++)
      run_job($urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH - 1),
              $urandom_range(0, 40), 1'($urandom_range(0, 1)), $urandom_range(0, 3), 0, 0);
    run_job($urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH - 1), 0, 0, 1, 0, 0);
    // Full-depth job: every address once.
    run_job($urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH - 1), DEPTH, 1, 0, 0, 0);

    // Abort during the second issue cycle of a len 8 job.
    ib = $urandom_range(0, DEPTH - 1); wb = $urandom_range(0, DEPTH - 1);
    start_job(ib, wb, 8, 0);
    @(posedge clk); #1;
    abort = 1; #1;
    chk("abort_rd_drop", in_rd_en, 0);
    @(posedge clk); #1;
    abort = 0;
    chk("abort_cmd_ready", cmd_ready, 1);
    chk("abort_busy", busy, 0);
    seen = 0;
    repeat (6) begin @(negedge clk); if (rsp_valid) seen = 1; end
    chk("abort_no_rsp", seen, 0);
    chk("abort_mac_en", men_cnt, 1);
    chk("abort_rd_count", rd_cnt, 1);
    chk("abort_result_kept", rsp_result, last_res);
    model_acc += dot4(in_mem[ib], wt_mem[wb]);

    // Follow-up job after abort keeps accumulating from the partial element.
    run_job($urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH - 1), 6, 0, 0, 0, 0);

    // Reset while draining.
    start_job(0, 0, 4, 0);
    repeat (4) @(posedge clk);
    #1;
    chk("drain_reached", {busy, in_rd_en}, 2'b10);
    reset_n = 0; #1;
    chk("rst_mid_strobes", {in_rd_en, wt_rd_en, mac_clear, mac_en, rsp_valid, busy}, 0);
    chk("rst_mid_addr", {in_rd_addr, wt_rd_addr}, 0);
    chk("rst_mid_result", rsp_result, 0);
    @(negedge clk); reset_n = 1;
    repeat (4) @(negedge clk);
    chk("rst_mid_no_rsp", rsp_valid, 0);
    chk("rst_mid_ready", cmd_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
